bcd_display_mux: RTL and testbench

BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

---
 rtl/bcd_display_mux.sv | 127 ++++++++++++
 tb/tb_bcd_display_mux.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_mux.sv
// Multiplexed BCD seven-segment display driver.
// Captures a packed BCD word on Load, then scans the digits one at a time,
// holding each digit for REFRESH_CYCLES cycles. All outputs are registered
// and trail the internal digit index by one cycle.
module bcd_display_mux #(
  parameter int unsigned DEC_DIGITS     = 2,
  parameter int unsigned REFRESH_CYCLES = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [DEC_DIGITS*4-1:0] DataBCD,
  input  logic                    Load,
  input  logic                    BlankLZ,
  output logic [6:0]              Seg,
  output logic [DEC_DIGITS-1:0]   Anode,
  output logic                    FrameWrap
);

  localparam int unsigned IdxW = (DEC_DIGITS > 1) ? $clog2(DEC_DIGITS) : 1;
  localparam int unsigned CntW = $clog2(REFRESH_CYCLES);

  logic [DEC_DIGITS*4-1:0] shadow_q, shadow_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [6:0]              seg_q, seg_d;
  logic [DEC_DIGITS-1:0]   anode_q, anode_d;
  logic                    fw_q, fw_d;

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-decimal codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    return pat;
  endfunction

  // Shadow capture and dwell/digit scan sequencing; Load never touches the scan.
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    if (Load) begin
      shadow_d = DataBCD;
    end
    if (cnt_q == CntW'(REFRESH_CYCLES - 1)) begin
      cnt_d = '0;
      if (idx_q == IdxW'(DEC_DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Output stage: anode select, segment decode with leading-zero blanking, frame marker.
  always_comb begin
    logic [DEC_DIGITS-1:0] lz;
    logic                  run;
    logic [3:0]            sel_nib;
    logic                  sel_lz;

    lz      = '0;
    run     = 1'b1;
    sel_nib = '0;
    sel_lz  = 1'b0;
    anode_d = '1;

    // lz[i] is set when nibble i and every more-significant nibble are zero.
    for (int i = int'(DEC_DIGITS) - 1; i >= 0; i--) begin
      run   = run & (shadow_q[i*4 +: 4] == 4'd0);
      lz[i] = run;
    end

    for (int i = 0; i < int'(DEC_DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        sel_nib    = shadow_q[i*4 +: 4];
        sel_lz     = lz[i];
        anode_d[i] = 1'b0;
      end
    end

    if (BlankLZ && (idx_q != '0) && sel_lz) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = ~seg_decode(sel_nib);
    end

    fw_d = (idx_q == '0) && (cnt_q == '0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      shadow_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      seg_q    <= 7'h7F;
      anode_q  <= '1;
      fw_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      seg_q    <= seg_d;
      anode_q  <= anode_d;
      fw_q     <= fw_d;
    end
  end

  assign Seg       = seg_q;
  assign Anode     = anode_q;
  assign FrameWrap = fw_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Self-checking bench for bcd_display_mux (2 digits, 4-cycle dwell).
// Expected outputs come from an arithmetic model: edges since reset release
// determine the displayed position, and the shadow value is held as an integer.
module tb_bcd_display_mux;

  localparam int N = 2;
  localparam int R = 4;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [7:0]   DataBCD = '0;
  logic         Load = 1'b0;
  logic         BlankLZ = 1'b0;
  logic [6:0]   Seg;
  logic [1:0]   Anode;
  logic         FrameWrap;

  int nchecks = 0;
  int nfail   = 0;

  // Model state
  int unsigned sh_m = 0;
  int unsigned pos  = 0;
  logic [6:0]  exp_seg = 7'h7F;
  logic [1:0]  exp_anode = 2'b11;
  logic        exp_fw = 1'b0;
  logic [6:0]  seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bcd_display_mux #(
    .DEC_DIGITS    (N),
    .REFRESH_CYCLES(R)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .DataBCD  (DataBCD),
    .Load     (Load),
    .BlankLZ  (BlankLZ),
    .Seg      (Seg),
    .Anode    (Anode),
    .FrameWrap(FrameWrap)
  );

  always #5 Clk = ~Clk;

  // Drive one cycle of inputs, advance one edge and update the model.
  task automatic step(input logic rst, input logic ld, input logic [7:0] d, input logic blz);
    int unsigned idx, upper, dig;
    Rst = rst; Load = ld; DataBCD = d; BlankLZ = blz;
    @(posedge Clk);
    if (rst) begin
      exp_anode = 2'b11; exp_seg = 7'h7F; exp_fw = 1'b0; sh_m = 0; pos = 0;
    end else begin
      idx   = (pos / R) % N;
      upper = sh_m >> (4 * idx);
      dig   = upper % 16;
      exp_fw = ((pos % (N * R)) == 0);
      exp_anode = 2'b11;
      exp_anode[idx] = 1'b0;
      if (blz && idx > 0 && upper == 0) exp_seg = 7'h7F;
      else if (dig > 9)                 exp_seg = 7'h3F;
      else                              exp_seg = ~seg_tab[dig];
      pos++;
      if (ld) sh_m = d;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      nchecks++;
      if ({Anode, Seg, FrameWrap} !== {2'b11, 7'h7F, 1'b0}) begin
        nfail++;
        $display("FAIL reset cyc%0d: got an=%b seg=%h fw=%b, want an=11 seg=7f fw=0",
                 i, Anode, Seg, FrameWrap);
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    nchecks++;
    if ({Anode, Seg, FrameWrap} !== {2'b10, 7'h40, 1'b1}) begin
      nfail++;
      $display("FAIL reset_release: got an=%b seg=%h fw=%b, want an=10 seg=40 fw=1",
               Anode, Seg, FrameWrap);
    end
  endtask

  // Load a value, then compare every cycle against the model for ncyc cycles.
  task automatic test_pattern(input string name, input logic [7:0] d, input logic blz,
                              input int ncyc);
    int fw_cnt = 0;
    step(1'b0, 1'b1, d, blz);
    for (int i = 0; i < ncyc; i++) begin
      step(1'b0, 1'b0, 8'hFF, blz);
      fw_cnt += int'(FrameWrap);
      nchecks++;
      if ({Anode, Seg, FrameWrap} !== {exp_anode, exp_seg, exp_fw}) begin
        nfail++;
        $display("FAIL %s cyc%0d: got an=%b seg=%h fw=%b, want an=%b seg=%h fw=%b",
                 name, i, Anode, Seg, FrameWrap, exp_anode, exp_seg, exp_fw);
      end
    end
    nchecks++;
    if (fw_cnt != ncyc / (N * R)) begin
      nfail++;
      $display("FAIL %s_framewrap_count: got %0d, want %0d", name, fw_cnt, ncyc / (N * R));
    end
  endtask

  // Load 8'h40 while digit 1 is in its second dwell cycle.
  task automatic test_midload();
    int guard = 0;
    step(1'b0, 1'b1, 8'h07, 1'b0);
    while (((pos - 1) % (N * R)) != 5 && guard < 20) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      guard++;
    end
    nchecks++;
    if (guard >= 20) begin
      nfail++;
      $display("FAIL midload_align: got guard=%0d, want <20", guard);
    end
    step(1'b0, 1'b1, 8'h40, 1'b0);
    nchecks++;
    if ({Anode, Seg} !== {2'b01, 7'h40}) begin
      nfail++;
      $display("FAIL midload_edge1: got an=%b seg=%h, want an=01 seg=40", Anode, Seg);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    nchecks++;
    if ({Anode, Seg} !== {2'b01, 7'h19}) begin
      nfail++;
      $display("FAIL midload_edge2: got an=%b seg=%h, want an=01 seg=19", Anode, Seg);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    nchecks++;
    if ({Anode, Seg, FrameWrap} !== {2'b10, 7'h40, 1'b1}) begin
      nfail++;
      $display("FAIL midload_dwell_end: got an=%b seg=%h fw=%b, want an=10 seg=40 fw=1",
               Anode, Seg, FrameWrap);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 8'h25, 1'b0);
    while (exp_anode != 2'b01) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h99, 1'b0);
    nchecks++;
    if ({Anode, Seg, FrameWrap} !== {2'b11, 7'h7F, 1'b0}) begin
      nfail++;
      $display("FAIL reset_mid: got an=%b seg=%h fw=%b, want an=11 seg=7f fw=0",
               Anode, Seg, FrameWrap);
    end
    for (int i = 0; i < R + 1; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      nchecks++;
      if ({Anode, Seg} !== ((i < R) ? {2'b10, 7'h40} : {2'b01, 7'h40})) begin
        nfail++;
        $display("FAIL reset_mid_after cyc%0d: got an=%b seg=%h", i, Anode, Seg);
      end
    end
  endtask

  task automatic test_random();
    logic       ld, blz;
    logic [7:0] d;
    for (int i = 0; i < 300; i++) begin
      ld  = ($urandom_range(0, 5) == 0);
      blz = $urandom_range(0, 1) == 1;
      d   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : {4'($urandom_range(0, 9)),
                                                          4'($urandom_range(0, 9))};
      if ($urandom_range(0, 3) == 0) d[7:4] = 4'h0;
      step(($urandom_range(0, 99) == 0), ld, d, blz);
      nchecks++;
      if ({Anode, Seg, FrameWrap} !== {exp_anode, exp_seg, exp_fw}) begin
        nfail++;
        $display("FAIL random cyc%0d: got an=%b seg=%h fw=%b, want an=%b seg=%h fw=%b",
                 i, Anode, Seg, FrameWrap, exp_anode, exp_seg, exp_fw);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern("load_25", 8'h25, 1'b0, 16);
    test_pattern("blank_07", 8'h07, 1'b1, 16);
    test_pattern("noblank_07", 8'h07, 1'b0, 8);
    test_pattern("dash_3a", 8'h3A, 1'b0, 8);
    test_pattern("blank_00", 8'h00, 1'b1, 8);
    test_midload();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule
